// File: rtl/seq_sched_pkg.sv
// Shared types and constants for the sequence-generator scheduler.
package seq_sched_pkg;

    localparam int NUM_REQ = 4;

    localparam logic [1:0] SEQ_FIBO   = 2'd0;
    localparam logic [1:0] SEQ_PRIME  = 2'd1;
    localparam logic [1:0] SEQ_SQUARE = 2'd2;
    localparam logic [1:0] SEQ_TRI    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESTART = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick; the requester after last_owner wins first.
module rr_arbiter4
    import seq_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last_owner,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         index,
    output logic               any
);

    // Walk from lowest to highest priority so the highest-priority hit is assigned last.
    always_comb begin
        logic [1:0] cand;
        index = 2'd0;
        any   = 1'b0;
        cand  = 2'd0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = last_owner + 2'(k);
            if (req[cand]) begin
                index = cand;
                any   = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign grant[gi] = any && (index == 2'(gi));
        end
    endgenerate

endmodule

// File: rtl/seq_scheduler.sv
// Grants one sequence generator to four requesters, counts emitted terms and
// guards each step with a watchdog.
module seq_scheduler
    import seq_sched_pkg::*;
#(
    parameter int TERMS_W   = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [TERMS_W-1:0] terms_cfg,
    input  logic               abort,
    input  logic               gen_step,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         gen_sel,
    output logic               gen_restart,
    output logic               gen_run,
    output logic               busy,
    output logic               done,
    output logic               timeout
);

    localparam logic [TERMS_W:0]   TERMS_FULL = {1'b1, {TERMS_W{1'b0}}};
    localparam logic [TERMS_W:0]   TERMS_ONE  = {{TERMS_W{1'b0}}, 1'b1};
    // Stepping from this value would hit all-ones, which counts as saturation.
    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    sched_state_t         state_reg;
    logic [1:0]           last_owner_reg;
    logic [TERMS_W:0]     terms_left_reg;
    logic [TIMEOUT_W-1:0] wdog_reg;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [1:0]           arb_index;
    logic                 arb_any;

    rr_arbiter4 u_arb (
        .req        (req),
        .last_owner (last_owner_reg),
        .grant      (arb_grant),
        .index      (arb_index),
        .any        (arb_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            last_owner_reg <= 2'd3;
            terms_left_reg <= '0;
            wdog_reg       <= '0;
            grant          <= '0;
            gen_sel        <= SEQ_FIBO;
            gen_restart    <= 1'b0;
            gen_run        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            gen_restart <= 1'b0;
            done        <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (arb_any) begin
                        state_reg      <= ST_RESTART;
                        grant          <= arb_grant;
                        gen_sel        <= arb_index;
                        gen_restart    <= 1'b1;
                        busy           <= 1'b1;
                        timeout        <= 1'b0;
                        last_owner_reg <= arb_index;
                        terms_left_reg <= (terms_cfg == '0) ? TERMS_FULL : {1'b0, terms_cfg};
                    end
                end
                ST_RESTART: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                        grant     <= '0;
                        busy      <= 1'b0;
                    end else begin
                        state_reg <= ST_RUN;
                        gen_run   <= 1'b1;
                        wdog_reg  <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                        grant     <= '0;
                        gen_run   <= 1'b0;
                        busy      <= 1'b0;
                    end else if (gen_step) begin
                        wdog_reg       <= '0;
                        terms_left_reg <= terms_left_reg - TERMS_ONE;
                        if (terms_left_reg == TERMS_ONE) begin
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
                            grant     <= '0;
                            gen_run   <= 1'b0;
                        end
                    end else if (wdog_reg == WDOG_LAST) begin
                        wdog_reg  <= wdog_reg + 1'b1;
                        timeout   <= 1'b1;
                        state_reg <= ST_DONE;
                        done      <= 1'b1;
                        grant     <= '0;
                        gen_run   <= 1'b0;
                    end else begin
                        wdog_reg <= wdog_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    grant     <= '0;
                    gen_run   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
